// File: rtl/ins_encoder.sv
// ins_encoder
//   Packs an instruction field bundle into a 32-bit instruction word, tags it
//   with a running 16-bit word address and queues it in a 2-entry FIFO that
//   feeds an instruction-memory write port.
//
//   Optional feature: define INS_ENC_CHECK_EN to enable illegal-bundle
//   detection (bundle dropped, sticky err, saturating err_cnt). Without it,
//   every bundle is encoded and err/err_cnt are tied to 0.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   field bundle handshake
//   opcode, funct, mem_rd instruction fields
//   rd, ra, rb, imm       register and immediate fields
//   addr_load, addr_base  load the word address counter
//   out_valid / out_ready encoded word handshake (FIFO head)
//   out_ins, out_addr     encoded word and its word address
//   err, err_cnt          sticky illegal flag, dropped-bundle count
module ins_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [2:0]  funct,
    input  logic        mem_rd,
    input  logic [4:0]  rd,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    input  logic [15:0] imm,
    input  logic        addr_load,
    input  logic [15:0] addr_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [15:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] OP_CAL    = 4'd0;
    localparam logic [3:0] OP_CALI   = 4'd1;
    localparam logic [3:0] OP_SHIFT  = 4'd2;
    localparam logic [3:0] OP_LOADI  = 4'd3;
    localparam logic [3:0] OP_MEMOP  = 4'd4;
    localparam logic [3:0] OP_BRANCH = 4'd5;
    localparam logic [3:0] OP_EXC    = 4'd6;
    localparam logic [3:0] OP_MULTI  = 4'd7;

    localparam int ENTRY_W = 48;  // {addr[15:0], ins[31:0]}

    logic [31:0] ins_enc;
    logic        bundle_legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic [15:0] tag_addr;

    logic [1:0]  count_q,  count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [15:0] addr_q,   addr_d;
    logic [ENTRY_W-1:0] head;

    // ------------------------------------------------------------------
    // Field packing. ra[3:0] shares bits 25:22 with imm[15:12] in the
    // I-type and BRANCH formats, so only ra[4] gets its own bit (26).
    // ------------------------------------------------------------------
    always_comb begin
        ins_enc          = '0;
        ins_enc[4:1]     = opcode;
        ins_enc[7:5]     = funct;
        ins_enc[31:27]   = rd;
        case (opcode)
            OP_CAL, OP_SHIFT: begin
                ins_enc[26:22] = ra;
                ins_enc[21:17] = rb;
            end
            OP_CALI, OP_LOADI: begin
                ins_enc[26]    = ra[4];
                ins_enc[25:10] = imm;
            end
            OP_MEMOP: begin
                ins_enc[26]    = ra[4];
                ins_enc[25:10] = imm;
                ins_enc[8]     = mem_rd;
                // A store has no destination; its data register goes on top.
                if (!mem_rd) begin
                    ins_enc[31:27] = rb;
                end
            end
            OP_BRANCH: begin
                ins_enc[31:27] = rb;
                ins_enc[26]    = ra[4];
                ins_enc[25:10] = imm;
            end
            default: begin
                // EXC, MULTI and unknown opcodes carry only rd/funct/opcode.
            end
        endcase
    end

`ifdef INS_ENC_CHECK_EN
    logic       err_q,     err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        bundle_legal = 1'b1;
        case (opcode)
            OP_CAL, OP_SHIFT, OP_EXC: begin
                bundle_legal = 1'b1;
            end
            OP_CALI, OP_LOADI, OP_MEMOP: begin
                if (ra[3:0] != imm[15:12]) bundle_legal = 1'b0;
            end
            OP_BRANCH: begin
                if (funct == 3'b100 || funct == 3'b101 || funct == 3'b110)
                    bundle_legal = 1'b0;
                if (ra[3:0] != imm[15:12]) bundle_legal = 1'b0;
            end
            OP_MULTI: begin
                if (!(funct == 3'b111 || funct == 3'b101 ||
                      funct == 3'b010 || funct == 3'b000))
                    bundle_legal = 1'b0;
            end
            default: begin
                bundle_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (accept && !bundle_legal) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    // imm[15:12] silently wins over ra[3:0]; nothing is ever dropped.
    assign bundle_legal = 1'b1;
    assign err          = 1'b0;
    assign err_cnt      = '0;
`endif

    // ------------------------------------------------------------------
    // Handshake and address counter
    // ------------------------------------------------------------------
    assign fifo_full = (count_q == 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    // rst_n gating keeps in_ready low while reset is held.
    assign in_ready  = rst_n & (!fifo_full | out_ready);
    assign accept    = in_valid & in_ready;
    assign push      = accept & bundle_legal;
    // A same-cycle load tags the accepted word with the new base.
    assign tag_addr  = addr_load ? addr_base : addr_q;

    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        addr_d   = addr_q;
        if (push) begin
            addr_d = tag_addr + 16'd1;  // wraps 0xFFFF -> 0x0000
        end else if (addr_load) begin
            addr_d = addr_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage, one register per entry
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    entry_d = {tag_addr, ins_enc};
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end
        end
    endgenerate

    assign head     = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;
    // Outputs read zero whenever nothing is queued.
    assign out_ins  = out_valid ? head[31:0]  : '0;
    assign out_addr = out_valid ? head[47:32] : '0;

endmodule

// File: tb/tb_ins_encoder.sv
// tb_ins_encoder
//   Table-driven directed test of ins_encoder: one bundle per record with
//   hand-computed expected word/address/error state, followed by hand-written
//   sequences for back-pressure, mid-stream reset and counter load.
module tb_ins_encoder;

    localparam logic [3:0] CAL = 4'd0, CALI = 4'd1, SHIFT = 4'd2, LOADI = 4'd3;
    localparam logic [3:0] MEMOP = 4'd4, BRANCH = 4'd5, EXC = 4'd6, MULTI = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [2:0]  funct;
    logic        mem_rd;
    logic [4:0]  rd, ra, rb;
    logic [15:0] imm;
    logic        addr_load;
    logic [15:0] addr_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [15:0] out_addr;
    logic        err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    ins_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .mem_rd    (mem_rd),
        .rd        (rd),
        .ra        (ra),
        .rb        (rb),
        .imm       (imm),
        .addr_load (addr_load),
        .addr_base (addr_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ins   (out_ins),
        .out_addr  (out_addr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  fn;
        logic        mrd;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [15:0] imm;
        logic        ld;
        logic [15:0] base;
        logic        ev;    // expect a word out
        logic [31:0] ins;
        logic [15:0] adr;
        logic        e;
        logic [7:0]  ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] fn,
                                input logic mrd, input logic [4:0] rd_i,
                                input logic [4:0] ra_i, input logic [4:0] rb_i,
                                input logic [15:0] imm_i, input logic ld,
                                input logic [15:0] base, input logic ev,
                                input logic [31:0] ins, input logic [15:0] adr,
                                input logic e, input logic [7:0] ec);
        vec_t v;
        v.op = op; v.fn = fn; v.mrd = mrd; v.rd = rd_i; v.ra = ra_i; v.rb = rb_i;
        v.imm = imm_i; v.ld = ld; v.base = base; v.ev = ev; v.ins = ins;
        v.adr = adr; v.e = e; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one bundle for one cycle with out_ready=1, then check the
    // result on the following cycle.
    task automatic run_vec(input vec_t v, input int i);
        @(negedge clk);
        in_valid = 1'b1; opcode = v.op; funct = v.fn; mem_rd = v.mrd;
        rd = v.rd; ra = v.ra; rb = v.rb; imm = v.imm;
        addr_load = v.ld; addr_base = v.base; out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; addr_load = 1'b0;
        #1;
        chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(v.ev));
        if (v.ev) begin
            chk($sformatf("vec%0d.out_ins", i), out_ins, v.ins);
            chk($sformatf("vec%0d.out_addr", i), 32'(out_addr), 32'(v.adr));
        end
        chk($sformatf("vec%0d.err", i), 32'(err), 32'(v.e));
        chk($sformatf("vec%0d.err_cnt", i), 32'(err_cnt), 32'(v.ec));
        $display("vec %0d op=%0d valid=%0b ins=0x%08h addr=0x%04h err=%0b cnt=%0d",
                 i, v.op, out_valid, out_ins, out_addr, err, err_cnt);
    endtask

    logic [47:0] exp_q[$];
    logic [47:0] exp_w;
    int idx, cyc, pops;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct = '0; mem_rd = 1'b0;
        rd = '0; ra = '0; rb = '0; imm = '0; addr_load = 1'b0; addr_base = '0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_ins", out_ins, 32'd0);
        chk("rst.out_addr", 32'(out_addr), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.err_cnt", 32'(err_cnt), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready_after", 32'(in_ready), 32'd1);

        // ---------------- vector table ----------------
        //              op      fn      mrd  rd     ra      rb     imm       ld  base      ev  ins            adr       e  ec
        vecs.push_back(mk(CALI,   3'b010, 0, 5'd3,  5'h15, 5'd0,  16'h5ABC, 1, 16'h0100, 1, 32'h1D6AF042, 16'h0100, 0, 0));
        vecs.push_back(mk(CAL,    3'd5,   0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 0, 16'h0000, 1, 32'h088600A0, 16'h0101, 0, 0));
        vecs.push_back(mk(SHIFT,  3'd7,   1, 5'd31, 5'd31, 5'd31, 16'h0000, 0, 16'h0000, 1, 32'hFFFE00E4, 16'h0102, 0, 0));
        vecs.push_back(mk(MEMOP,  3'd0,   0, 5'd9,  5'd0,  5'd7,  16'h0123, 0, 16'h0000, 1, 32'h38048C08, 16'h0103, 0, 0));
        vecs.push_back(mk(MEMOP,  3'd3,   1, 5'd9,  5'h12, 5'd7,  16'h2FFF, 0, 16'h0000, 1, 32'h4CBFFD68, 16'h0104, 0, 0));
        vecs.push_back(mk(LOADI,  3'd0,   0, 5'h10, 5'h0F, 5'd0,  16'hF001, 0, 16'h0000, 1, 32'h83C00406, 16'h0105, 0, 0));
        vecs.push_back(mk(BRANCH, 3'b011, 0, 5'd1,  5'h1A, 5'h15, 16'hA5A5, 0, 16'h0000, 1, 32'hAE96946A, 16'h0106, 0, 0));
        vecs.push_back(mk(EXC,    3'd4,   1, 5'd12, 5'h1F, 5'h1F, 16'hFFFF, 0, 16'h0000, 1, 32'h6000008C, 16'h0107, 0, 0));
        vecs.push_back(mk(MULTI,  3'b010, 0, 5'd5,  5'd3,  5'd4,  16'h1234, 0, 16'h0000, 1, 32'h2800004E, 16'h0108, 0, 0));
`ifdef INS_ENC_CHECK_EN
        vecs.push_back(mk(BRANCH, 3'b101, 0, 5'd0,  5'd0,  5'd0,  16'h0000, 0, 16'h0000, 0, 32'h0,        16'h0000, 1, 1));
        vecs.push_back(mk(CAL,    3'd0,   0, 5'd2,  5'd0,  5'd0,  16'h0000, 0, 16'h0000, 1, 32'h10000000, 16'h0109, 1, 1));
        vecs.push_back(mk(4'hF,   3'd0,   0, 5'd2,  5'd0,  5'd0,  16'h0000, 0, 16'h0000, 0, 32'h0,        16'h0000, 1, 2));
        vecs.push_back(mk(MULTI,  3'b001, 0, 5'd2,  5'd0,  5'd0,  16'h0000, 0, 16'h0000, 0, 32'h0,        16'h0000, 1, 3));
        vecs.push_back(mk(CALI,   3'd0,   0, 5'd0,  5'h1F, 5'd0,  16'h0000, 0, 16'h0000, 0, 32'h0,        16'h0000, 1, 4));
        vecs.push_back(mk(CAL,    3'd0,   0, 5'd1,  5'd0,  5'd0,  16'h0000, 1, 16'hFFFF, 1, 32'h08000000, 16'hFFFF, 1, 4));
        vecs.push_back(mk(CAL,    3'd0,   0, 5'd4,  5'd0,  5'd0,  16'h0000, 0, 16'h0000, 1, 32'h20000000, 16'h0000, 1, 4));
`else
        vecs.push_back(mk(BRANCH, 3'b101, 0, 5'd0,  5'd0,  5'd0,  16'h0000, 0, 16'h0000, 1, 32'h000000AA, 16'h0109, 0, 0));
        vecs.push_back(mk(CALI,   3'd0,   0, 5'd0,  5'h1F, 5'd0,  16'h0000, 0, 16'h0000, 1, 32'h04000002, 16'h010A, 0, 0));
        vecs.push_back(mk(CAL,    3'd0,   0, 5'd1,  5'd0,  5'd0,  16'h0000, 1, 16'hFFFF, 1, 32'h08000000, 16'hFFFF, 0, 0));
        vecs.push_back(mk(CAL,    3'd0,   0, 5'd4,  5'd0,  5'd0,  16'h0000, 0, 16'h0000, 1, 32'h20000000, 16'h0000, 0, 0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // ---------------- back-pressure: 5 bundles, sink stalled ----------------
        @(negedge clk);
        idx = 0; cyc = 0; pops = 0;
        while ((idx < 5 || exp_q.size() != 0) && cyc < 40) begin
            out_ready = (cyc >= 6);
            if (idx < 5) begin
                in_valid = 1'b1; opcode = CAL; funct = 3'd0; mem_rd = 1'b0;
                rd = 5'(idx + 1); ra = '0; rb = '0; imm = '0;
                addr_load = (idx == 0); addr_base = 16'h2000;
            end else begin
                in_valid = 1'b0; addr_load = 1'b0;
            end
            #1;
            if (cyc == 4) begin
                chk("bp.in_ready_low", 32'(in_ready), 32'd0);
                chk("bp.accepted", 32'(idx), 32'd2);
                chk("bp.hold_addr", 32'(out_addr), 32'h2000);
                chk("bp.hold_ins", out_ins, 32'h08000000);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp.spurious", 32'(out_addr), 32'hFFFFFFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk($sformatf("bp.pop%0d.ins", pops), out_ins, exp_w[31:0]);
                    chk($sformatf("bp.pop%0d.addr", pops), 32'(out_addr), 32'(exp_w[47:32]));
                end
                $display("bp pop %0d ins=0x%08h addr=0x%04h", pops, out_ins, out_addr);
                pops++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({16'h2000 + 16'(idx), 5'(idx + 1), 27'd0});
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("bp.pops", 32'(pops), 32'd5);
        chk("bp.pending", 32'(exp_q.size() + (5 - idx)), 32'd0);

        // ---------------- reset with 2 words queued ----------------
        out_ready = 1'b0; in_valid = 1'b1; opcode = CAL; funct = 3'd0;
        rd = 5'd9; addr_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rstmid.queued", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk); #1;
        chk("rstmid.out_valid", 32'(out_valid), 32'd0);
        chk("rstmid.out_addr", 32'(out_addr), 32'd0);
        chk("rstmid.err_cnt", 32'(err_cnt), 32'd0);
        chk("rstmid.err", 32'(err), 32'd0);
        rst_n = 1'b1;
        $display("reset mid-stream: out_valid=%0b err_cnt=%0d", out_valid, err_cnt);
        // Counter restarts at 0.
        run_vec(mk(CAL, 3'd0, 0, 5'd3, 5'd0, 5'd0, 16'h0000, 0, 16'h0000, 1, 32'h18000000, 16'h0000, 0, 0), 100);

        // ---------------- load without acceptance ----------------
        @(negedge clk);
        addr_load = 1'b1; addr_base = 16'h3000; in_valid = 1'b0;
        run_vec(mk(CAL, 3'd0, 0, 5'd6, 5'd0, 5'd0, 16'h0000, 0, 16'h0000, 1, 32'h30000000, 16'h3000, 0, 0), 101);
        @(negedge clk); #1;
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
